// File: rtl/face_color_pkg.sv
// Shared types and default constants for the cube-face colour sampler.
package face_color_pkg;

    localparam int CH_W_DEF       = 10;
    localparam int WIN_LOG2_DEF   = 2;
    localparam int FRAME_LOG2_DEF = 1;

    // Window edge in pixels and the total averaging shift (window area x frames).
    localparam int WIN   = 2 ** WIN_LOG2_DEF;
    localparam int SHIFT = 2 * WIN_LOG2_DEF + FRAME_LOG2_DEF;

    typedef struct packed {
        logic [CH_W_DEF-1:0] r;
        logic [CH_W_DEF-1:0] g;
        logic [CH_W_DEF-1:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_FRAME,
        ACCUM,
        COMMIT
    } fcs_state_t;

endpackage

// File: rtl/axis_locator.sv
// Finds which sample window (if any) along one axis contains a coordinate.
// Purely combinational; the parent registers hit/index.
module axis_locator #(
    parameter int GRID     = 3,
    parameter int COORD_W  = 11,
    parameter int WIN_LOG2 = 2,
    parameter int IDX_W    = $clog2(GRID)
) (
    input  logic [COORD_W+1:0] starts [GRID],
    input  logic [COORD_W-1:0] coord,
    output logic               hit,
    output logic [IDX_W-1:0]   index
);

    localparam int WIN_PX = 2 ** WIN_LOG2;
    localparam int EXT_W  = COORD_W + 3;

    logic [EXT_W-1:0] c_ext;
    logic [EXT_W-1:0] lo;
    logic [EXT_W-1:0] hi;

    // Scan windows from the top index down so the lowest matching window wins.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        c_ext = EXT_W'(coord);
        lo    = '0;
        hi    = '0;
        for (int i = GRID - 1; i >= 0; i--) begin
            lo = EXT_W'(starts[i]);
            hi = lo + EXT_W'(WIN_PX);
            if (c_ext >= lo && c_ext < hi) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/face_color_sampler.sv
// Samples a GRID x GRID cube face: each sticker colour is the mean of a small
// window centred on the sticker, averaged over several frames.
module face_color_sampler
    import face_color_pkg::*;
#(
    parameter int GRID       = 3,
    parameter int CH_W       = 10,
    parameter int COORD_W    = 11,
    parameter int WIN_LOG2   = 2,
    parameter int FRAME_LOG2 = 1,
    parameter int MAX_X      = 1279,
    parameter int MAX_Y      = 959
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Execute,
    input  logic                         pix_valid,
    input  logic                         frame_start,
    input  logic [3*CH_W-1:0]            pixelValue,
    input  logic [COORD_W-1:0]           X_Cont,
    input  logic [COORD_W-1:0]           Y_Cont,
    input  logic [COORD_W-1:0]           CubeX_Start,
    input  logic [COORD_W-1:0]           CubeY_Start,
    input  logic [9:0]                   N,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [GRID*GRID*3*CH_W-1:0]  Color
);

    localparam int WIN_PX     = 2 ** WIN_LOG2;
    localparam int HALF_WIN   = 2 ** (WIN_LOG2 - 1);
    localparam int FRAMES     = 2 ** FRAME_LOG2;
    localparam int SHIFT_BITS = 2 * WIN_LOG2 + FRAME_LOG2;
    localparam int ACC_W      = CH_W + SHIFT_BITS;
    localparam int POS_W      = COORD_W + 2;
    localparam int NSTK       = GRID * GRID;
    localparam int IDX_W      = $clog2(GRID);
    localparam int K_W        = $clog2(NSTK);
    localparam int FC_W       = FRAME_LOG2 + 1;

    fcs_state_t state, state_next;

    logic [COORD_W-1:0] org_x;
    logic [COORD_W-1:0] org_y;
    logic [9:0]         pitch;

    logic [POS_W-1:0] col_start [GRID];
    logic [POS_W-1:0] row_start [GRID];
    logic             cfg_bad;

    logic             col_hit, row_hit;
    logic [IDX_W-1:0] col_idx, row_idx;
    logic [K_W-1:0]   stk_idx;

    logic [FC_W-1:0]  frame_cnt;
    logic             draining;
    logic             drain_cnt;
    logic             fs_now, last_frame, end_frame, take;

    logic              vld_p1;
    logic [K_W-1:0]    idx_p1;
    logic [3*CH_W-1:0] pix_p1;

    logic [ACC_W-1:0]            acc [NSTK][3];
    logic [NSTK*3*CH_W-1:0]      color_q;

    // Divide an accumulator by window area x frame count, truncating.
    function automatic logic [CH_W-1:0] avg_shift(input logic [ACC_W-1:0] a);
        return CH_W'(a >> SHIFT_BITS);
    endfunction

    // Window start positions derived from the latched origin and pitch.
    always_comb begin
        for (int i = 0; i < GRID; i++) begin
            col_start[i] = POS_W'(org_x) + POS_W'(i) * POS_W'(pitch)
                         + POS_W'(pitch >> 1) - POS_W'(HALF_WIN);
            row_start[i] = POS_W'(org_y) + POS_W'(i) * POS_W'(pitch)
                         + POS_W'(pitch >> 1) - POS_W'(HALF_WIN);
        end
    end

    // Configuration sanity: pitch large enough and last window on-sensor.
    always_comb begin
        cfg_bad = (pitch < 10'(WIN_PX))
               || ((pitch >> 1) < 10'(HALF_WIN))
               || ((POS_W+1)'(col_start[GRID-1]) + (POS_W+1)'(WIN_PX - 1) > (POS_W+1)'(MAX_X))
               || ((POS_W+1)'(row_start[GRID-1]) + (POS_W+1)'(WIN_PX - 1) > (POS_W+1)'(MAX_Y));
    end

    axis_locator #(
        .GRID     (GRID),
        .COORD_W  (COORD_W),
        .WIN_LOG2 (WIN_LOG2),
        .IDX_W    (IDX_W)
    ) u_loc_x (
        .starts (col_start),
        .coord  (X_Cont),
        .hit    (col_hit),
        .index  (col_idx)
    );

    axis_locator #(
        .GRID     (GRID),
        .COORD_W  (COORD_W),
        .WIN_LOG2 (WIN_LOG2),
        .IDX_W    (IDX_W)
    ) u_loc_y (
        .starts (row_start),
        .coord  (Y_Cont),
        .hit    (row_hit),
        .index  (row_idx)
    );

    // Frame boundary and pixel acceptance; the frame-ending pixel of the last frame is dropped.
    always_comb begin
        fs_now     = pix_valid & frame_start;
        last_frame = (frame_cnt == FC_W'(FRAMES - 1));
        end_frame  = (state == ACCUM) && !draining && fs_now && last_frame;
        take       = pix_valid && (((state == WAIT_FRAME) && frame_start)
                                || ((state == ACCUM) && !draining && !end_frame));
        stk_idx    = K_W'(row_idx) * K_W'(GRID) + K_W'(col_idx);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (Execute) state_next = SETUP;
            SETUP:      state_next = cfg_bad ? COMMIT : WAIT_FRAME;
            WAIT_FRAME: if (fs_now) state_next = ACCUM;
            ACCUM:      if (draining && drain_cnt) state_next = COMMIT;
            COMMIT:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Control: handshake, configuration latch, frame counting and drain timing.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            org_x     <= '0;
            org_y     <= '0;
            pitch     <= '0;
            frame_cnt <= '0;
            draining  <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (Execute) begin
                        org_x   <= CubeX_Start;
                        org_y   <= CubeY_Start;
                        pitch   <= N;
                        busy    <= 1'b1;
                        cfg_err <= 1'b0;
                    end
                end
                SETUP: begin
                    cfg_err   <= cfg_bad;
                    frame_cnt <= '0;
                    draining  <= 1'b0;
                    drain_cnt <= 1'b0;
                end
                ACCUM: begin
                    if (end_frame) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        draining  <= 1'b1;
                        drain_cnt <= 1'b0;
                    end else if (draining) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end else if (fs_now) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                COMMIT: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Stage 1: register the located pixel and its sticker index.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= take && col_hit && row_hit;
            idx_p1 <= stk_idx;
            pix_p1 <= pixelValue;
        end
    end

    // Stage 2: accumulate each channel into the sticker's running sum.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int k = 0; k < NSTK; k++)
                for (int ch = 0; ch < 3; ch++)
                    acc[k][ch] <= '0;
        end else if (state == SETUP) begin
            if (!cfg_bad)
                for (int k = 0; k < NSTK; k++)
                    for (int ch = 0; ch < 3; ch++)
                        acc[k][ch] <= '0;
        end else if (vld_p1) begin
            for (int ch = 0; ch < 3; ch++)
                acc[idx_p1][ch] <= acc[idx_p1][ch] + ACC_W'(pix_p1[ch*CH_W +: CH_W]);
        end
    end

    // Publish averaged colours only on a clean commit; otherwise hold.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            color_q <= '0;
        end else if (state == COMMIT && !cfg_err) begin
            for (int k = 0; k < NSTK; k++)
                for (int ch = 0; ch < 3; ch++)
                    color_q[k*3*CH_W + ch*CH_W +: CH_W] <= avg_shift(acc[k][ch]);
        end
    end

    assign Color = color_q;

endmodule

// File: tb/tb_face_color_sampler.sv
// Directed bench for face_color_sampler with default parameters.
module tb_face_color_sampler;

    localparam int PW    = 30;
    localparam int CLR_W = 9 * PW;

    logic              Clk = 1'b0;
    logic              Reset, Execute, pix_valid, frame_start;
    logic [PW-1:0]     pixelValue;
    logic [10:0]       X_Cont, Y_Cont, CubeX_Start, CubeY_Start;
    logic [9:0]        N;
    logic              busy, done, cfg_err;
    logic [CLR_W-1:0]  Color;
    logic [CLR_W-1:0]  prev;

    int vectors     = 0;
    int miscompares = 0;
    int busy_low    = 0;
    bit mon_busy    = 0;
    bit gaps        = 0;
    int gap_ctr     = 0;

    // Window starts for origin (100,80), pitch 60: 100 + 60c + 30 - 2.
    int col_x [3] = '{128, 188, 248};
    int row_y [3] = '{108, 168, 228};

    face_color_sampler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Execute     (Execute),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .pixelValue  (pixelValue),
        .X_Cont      (X_Cont),
        .Y_Cont      (Y_Cont),
        .CubeX_Start (CubeX_Start),
        .CubeY_Start (CubeY_Start),
        .N           (N),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .Color       (Color)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
        if (mon_busy && busy !== 1'b1) busy_low++;
    endtask

    function automatic logic [PW-1:0] pix_of(input int mode, input int f, input int k);
        if (mode == 0) return {10'd100, 10'd200, 10'd300};
        if (f == 1 && k == 4) return {10'd1023, 10'd1023, 10'd1023};
        return '0;
    endfunction

    function automatic logic [CLR_W-1:0] exp_color(input int mode);
        logic [CLR_W-1:0] e;
        e = '0;
        for (int k = 0; k < 9; k++) begin
            if (mode == 0)   e[k*PW +: PW] = {10'd100, 10'd200, 10'd300};
            else if (k == 4) e[k*PW +: PW] = {10'd511, 10'd511, 10'd511};
        end
        return e;
    endfunction

    task automatic put_pix(input bit fs, input int x, input int y, input logic [PW-1:0] v);
        if (gaps) begin
            gap_ctr++;
            if (gap_ctr == 3) begin
                gap_ctr     = 0;
                pix_valid   = 1'b0;
                frame_start = 1'b0;
                X_Cont      = 11'(col_x[0]);
                Y_Cont      = 11'(row_y[0]);
                pixelValue  = {10'd1023, 10'd1023, 10'd1023};
                step();
            end
        end
        pix_valid   = 1'b1;
        frame_start = fs;
        X_Cont      = 11'(x);
        Y_Cont      = 11'(y);
        pixelValue  = v;
        step();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Two frames of sticker windows plus off-by-one decoys, then the frame-ending pixel.
    task automatic stream(input int mode, input bit abort, input bit poke);
        logic [PW-1:0] dec;
        dec = {10'd1023, 10'd1023, 10'd1023};
        step();
        for (int f = 0; f < 2; f++) begin
            put_pix(1'b1, 0, 0, {10'd5, 10'd5, 10'd5});
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (abort && f == 1 && r * 3 + c == 2) begin
                        Reset = 1'b0;
                        step();
                        Reset = 1'b1;
                        return;
                    end
                    if (poke && f == 0 && r * 3 + c == 4) begin
                        Execute     = 1'b1;
                        CubeX_Start = 11'd1200;
                        N           = 10'd3;
                    end
                    for (int dy = 0; dy < 4; dy++)
                        for (int dx = 0; dx < 4; dx++)
                            put_pix(1'b0, col_x[c] + dx, row_y[r] + dy, pix_of(mode, f, r * 3 + c));
                    Execute     = 1'b0;
                    CubeX_Start = 11'd100;
                    N           = 10'd60;
                    put_pix(1'b0, col_x[c] - 1, row_y[r], dec);
                    put_pix(1'b0, col_x[c] + 4, row_y[r], dec);
                    put_pix(1'b0, col_x[c], row_y[r] - 1, dec);
                    put_pix(1'b0, col_x[c], row_y[r] + 4, dec);
                end
            end
        end
        put_pix(1'b1, col_x[0], row_y[0], dec);
    endtask

    task automatic start_exec(input int x, input int y, input int n);
        CubeX_Start = 11'(x);
        CubeY_Start = 11'(y);
        N           = 10'(n);
        Execute     = 1'b1;
        step();
        Execute     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Execute = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
        pixelValue = '0; X_Cont = '0; Y_Cont = '0;
        CubeX_Start = 11'd100; CubeY_Start = 11'd80; N = 10'd60;
        repeat (3) step();
        vectors += 4;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); miscompares++; end
        if (done !== 1'b0) begin $display("FAIL reset_done: got %b required 0", done); miscompares++; end
        if (cfg_err !== 1'b0) begin $display("FAIL reset_cfg_err: got %b required 0", cfg_err); miscompares++; end
        if (Color !== '0) begin $display("FAIL reset_color: got %h required 0", Color); miscompares++; end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_uniform();
        start_exec(100, 80, 60);
        vectors++;
        if (busy !== 1'b1) begin $display("FAIL uniform_busy_start: got %b required 1", busy); miscompares++; end
        busy_low = 0;
        mon_busy = 1;
        stream(0, 1'b0, 1'b0);
        mon_busy = 0;
        vectors++;
        if (busy_low !== 0) begin $display("FAIL uniform_busy_held: %0d low cycles, required 0", busy_low); miscompares++; end
        wait_done("uniform");
        vectors += 3;
        if (busy !== 1'b0) begin $display("FAIL uniform_busy_at_done: got %b required 0", busy); miscompares++; end
        if (cfg_err !== 1'b0) begin $display("FAIL uniform_cfg_err: got %b required 0", cfg_err); miscompares++; end
        if (Color !== exp_color(0)) begin $display("FAIL uniform_color: got %h required %h", Color, exp_color(0)); miscompares++; end
        step();
        vectors++;
        if (done !== 1'b0) begin $display("FAIL uniform_done_pulse: got %b required 0", done); miscompares++; end
    endtask

    task automatic test_truncation();
        start_exec(100, 80, 60);
        stream(1, 1'b0, 1'b0);
        vectors++;
        if (Color !== exp_color(0)) begin $display("FAIL trunc_color_stable: got %h required %h", Color, exp_color(0)); miscompares++; end
        wait_done("trunc");
        vectors++;
        if (Color !== exp_color(1)) begin $display("FAIL trunc_color: got %h required %h", Color, exp_color(1)); miscompares++; end
        step();
    endtask

    task automatic test_small_pitch();
        prev = Color;
        start_exec(100, 80, 3);
        step();
        vectors++;
        if (done !== 1'b0) begin $display("FAIL pitch_done_early: got %b required 0", done); miscompares++; end
        step();
        vectors += 4;
        if (done !== 1'b1) begin $display("FAIL pitch_done: got %b required 1", done); miscompares++; end
        if (cfg_err !== 1'b1) begin $display("FAIL pitch_cfg_err: got %b required 1", cfg_err); miscompares++; end
        if (busy !== 1'b0) begin $display("FAIL pitch_busy: got %b required 0", busy); miscompares++; end
        if (Color !== prev) begin $display("FAIL pitch_color_held: got %h required %h", Color, prev); miscompares++; end
        step();
    endtask

    task automatic test_x_overflow();
        prev = Color;
        start_exec(1200, 80, 60);
        vectors++;
        if (cfg_err !== 1'b0) begin $display("FAIL xovf_cfg_err_cleared: got %b required 0", cfg_err); miscompares++; end
        step();
        step();
        vectors += 3;
        if (done !== 1'b1) begin $display("FAIL xovf_done: got %b required 1", done); miscompares++; end
        if (cfg_err !== 1'b1) begin $display("FAIL xovf_cfg_err: got %b required 1", cfg_err); miscompares++; end
        if (Color !== prev) begin $display("FAIL xovf_color_held: got %h required %h", Color, prev); miscompares++; end
        step();
    endtask

    task automatic test_reset_mid();
        start_exec(100, 80, 60);
        vectors++;
        if (cfg_err !== 1'b0) begin $display("FAIL rmid_cfg_err_cleared: got %b required 0", cfg_err); miscompares++; end
        stream(0, 1'b1, 1'b0);
        vectors += 3;
        if (busy !== 1'b0) begin $display("FAIL rmid_busy: got %b required 0", busy); miscompares++; end
        if (done !== 1'b0) begin $display("FAIL rmid_done: got %b required 0", done); miscompares++; end
        if (Color !== '0) begin $display("FAIL rmid_color: got %h required 0", Color); miscompares++; end
        step();
        start_exec(100, 80, 60);
        stream(0, 1'b0, 1'b0);
        wait_done("rmid_rerun");
        vectors += 2;
        if (Color !== exp_color(0)) begin $display("FAIL rmid_rerun_color: got %h required %h", Color, exp_color(0)); miscompares++; end
        if (cfg_err !== 1'b0) begin $display("FAIL rmid_rerun_cfg_err: got %b required 0", cfg_err); miscompares++; end
        step();
    endtask

    task automatic test_back_to_back();
        gaps    = 1;
        gap_ctr = 0;
        start_exec(100, 80, 60);
        stream(1, 1'b0, 1'b1);
        gaps = 0;
        wait_done("b2b");
        vectors += 2;
        if (Color !== exp_color(1)) begin $display("FAIL b2b_color: got %h required %h", Color, exp_color(1)); miscompares++; end
        if (cfg_err !== 1'b0) begin $display("FAIL b2b_cfg_err: got %b required 0", cfg_err); miscompares++; end
        repeat (3) step();
        vectors += 2;
        if (done !== 1'b0) begin $display("FAIL b2b_no_second_done: got %b required 0", done); miscompares++; end
        if (busy !== 1'b0) begin $display("FAIL b2b_idle_busy: got %b required 0", busy); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_truncation();
        test_small_pitch();
        test_x_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/face_color_sampler.md
Name: face_color_sampler

Overview:
- Parametrised successor to the single-pixel colour grabber. Samples a GRID x GRID cube face from the CCD pixel stream.
- Sticker colour = mean of a 2^WIN_LOG2 x 2^WIN_LOG2 window centred on each sticker, further averaged over 2^FRAME_LOG2 frames.
- Sits between the cube-origin detector / pitch source and the solver control unit. Publishes all sticker colours at once with a start/done handshake.

Parameters:
- GRID, 3, stickers per face edge (2..5); sticker index = row*GRID+col, row-major
- CH_W, 10, bits per colour channel; pixel = {R,G,B} = 3*CH_W bits
- COORD_W, 11, width of X/Y coordinates and origin
- WIN_LOG2, 2, log2 of sample window edge (window 4x4 = 16 px)
- FRAME_LOG2, 1, log2 of frames averaged (2 frames)
- MAX_X, 1279, last valid X coordinate
- MAX_Y, 959, last valid Y coordinate

Ports:
- Clk  in  1  single clock
- Reset  in  1  synchronous, active-low reset
- Execute  in  1  start request; sampled only in IDLE
- pix_valid  in  1  pixelValue/X_Cont/Y_Cont valid this cycle
- frame_start  in  1  one-cycle pulse at first pixel of each frame (coincides with that pixel)
- pixelValue  in  3*CH_W  {R,G,B}
- X_Cont  in  COORD_W  pixel X
- Y_Cont  in  COORD_W  pixel Y
- CubeX_Start  in  COORD_W  face top-left X; latched on accepted Execute
- CubeY_Start  in  COORD_W  face top-left Y; latched on accepted Execute
- N  in  10  sticker pitch in pixels; latched on accepted Execute
- busy  out  1  high from accepted Execute until done
- done  out  1  one-cycle pulse at end of operation
- cfg_err  out  1  sticky error from last operation
- Color  out  GRID*GRID*3*CH_W  sticker colours; sticker k at bits [k*3*CH_W +: 3*CH_W]

Behaviour:
- Reset (Reset==0 at posedge): state IDLE; busy=0, done=0, cfg_err=0; Color=0; all accumulators, frame counter and pipeline registers cleared. Applies mid-operation: abort, Color keeps the reset value 0.
- States: IDLE -> SETUP -> WAIT_FRAME -> ACCUM -> COMMIT -> IDLE.
- IDLE:
  - Execute=1 latches origin and N, sets busy, clears cfg_err.
  - Execute in any other state is ignored.
- SETUP (1 cycle):
  - Window starts: colX[c] = CubeX_Start + c*N + (N>>1) - (2^(WIN_LOG2-1)); rowY[r] likewise. c, r in 0..GRID-1. Computed at COORD_W+2 bits, unsigned.
  - cfg_err is set if any of: N < 2^WIN_LOG2; colX[GRID-1]+2^WIN_LOG2-1 > MAX_X; rowY[GRID-1]+2^WIN_LOG2-1 > MAX_Y; (N>>1) < 2^(WIN_LOG2-1).
  - On error: -> COMMIT with Color unchanged.
  - Otherwise: clear accumulators, frame counter=0, -> WAIT_FRAME.
- WAIT_FRAME: waits for frame_start&pix_valid. That pixel is the first accumulated one; -> ACCUM.
- ACCUM, 2-stage pipeline:
  - Stage 1: locate. Column hit c if colX[c] <= X_Cont < colX[c]+2^WIN_LOG2; row hit likewise. Register hit flag, sticker index and pixel.
  - Stage 2: add each channel into acc[k][ch]. Width CH_W+2*WIN_LOG2+FRAME_LOG2, no saturation needed.
  - Pixels with pix_valid=0 or no hit are discarded.
  - frame_start&pix_valid in ACCUM ends the current frame; frame counter increments.
  - When the counter reaches 2^FRAME_LOG2: that pixel is not accumulated; wait 2 cycles for pipeline drain; -> COMMIT.
  - Otherwise that pixel starts the next frame and is accumulated.
- COMMIT (1 cycle):
  - If no cfg_err: Color[k][ch] = acc[k][ch] >> (2*WIN_LOG2+FRAME_LOG2), truncating.
  - done=1, busy=0 registered on exit; -> IDLE.
- Latency from accepted Execute: 1 (SETUP) + wait to frame_start + 2^FRAME_LOG2 frames + 2 drain + 1 COMMIT. done asserts the cycle after COMMIT.
- Color changes only in COMMIT; it is stable at all other times.

Decomposition:
- Package face_color_pkg:
  - rgb_t packed struct {r,g,b}, CH_W each
  - state enum fcs_state_t {IDLE,SETUP,WAIT_FRAME,ACCUM,COMMIT}
  - localparams WIN=2**WIN_LOG2 and SHIFT=2*WIN_LOG2+FRAME_LOG2
- Sub-module axis_locator, instantiated twice (X and Y):
  - Inputs: GRID window starts, coordinate.
  - Outputs: hit, index ($clog2(GRID) bits).
  - Combinational; the parent registers its outputs.

Test Plan:
- Uniform frames {R,G,B}=(100,200,300), origin (100,80), N=60, default params. Two frames -> single done; all 9 Color entries = (100,200,300); busy high throughout, low after done.
- Frame 1 all pixels 0, frame 2 sticker 4 window = (1023,1023,1023), rest 0 -> Color[4] = (511,511,511), all other stickers 0 (truncation check).
- N=3 -> cfg_err=1, done 2 cycles after Execute, Color unchanged from previous run; next valid Execute clears cfg_err.
- Origin (1200,80), N=60 (window exceeds MAX_X) -> cfg_err=1, no frame consumed.
- Reset low during ACCUM of frame 2 -> next cycle busy=0, done=0, Color all 0. Fresh Execute then completes normally.
- Execute pulsed while busy, and pix_valid gaps of 1 cycle every 3 pixels -> second Execute ignored, results identical to the gap-free run.
